// File: rtl/load_buffer_fill_unit.sv
// Two 8-word load buffers filled by a sequential burst FSM from a data-memory read port,
// kept coherent with memory-stage stores and guarded by a load stall when a bank is not valid.
module load_buffer_fill_unit #(
    parameter int DEPTH_LOG2 = 3,
    parameter int ADDR_W     = 32
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic                  fill_start,
    input  logic                  fill_bank,
    input  logic [ADDR_W-1:0]     fill_base,
    output logic                  fill_busy,
    output logic                  mem_req,
    output logic [ADDR_W-1:0]     mem_addr,
    input  logic                  mem_ack,
    input  logic [31:0]           mem_rdata,
    input  logic                  snoop_we,
    input  logic [ADDR_W-1:0]     snoop_addr,
    input  logic [31:0]           snoop_data,
    input  logic [DEPTH_LOG2-1:0] buf_val_1_addr,
    output logic [31:0]           buf_val_1_select,
    input  logic [DEPTH_LOG2-1:0] buf_val_2_addr,
    output logic [31:0]           buf_val_2_select,
    input  logic                  load_buff_a,
    input  logic                  load_buff_b,
    output logic                  valid_a,
    output logic                  valid_b,
    output logic                  ld_stall
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic {IDLE, FILL} state_t;

    state_t                state_q, state_d;
    logic                  tgt_q, tgt_d;
    logic [DEPTH_LOG2-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0]     base_a_q, base_a_d;
    logic [ADDR_W-1:0]     base_b_q, base_b_d;
    logic                  valid_a_q, valid_a_d;
    logic                  valid_b_q, valid_b_d;

    logic [31:0] bank_a_q [DEPTH];
    logic [31:0] bank_b_q [DEPTH];

    logic [ADDR_W-1:0]     snoop_word, off_a, off_b;
    logic [DEPTH_LOG2-1:0] idx_a, idx_b;
    logic                  hit_a, hit_b, upd_a, upd_b;
    logic                  filling, fill_we_a, fill_we_b;
    logic [5:0]            unused_low_bits;

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q   <= IDLE;
            tgt_q     <= 1'b0;
            cnt_q     <= '0;
            base_a_q  <= '0;
            base_b_q  <= '0;
            valid_a_q <= 1'b0;
            valid_b_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tgt_q     <= tgt_d;
            cnt_q     <= cnt_d;
            base_a_q  <= base_a_d;
            base_b_q  <= base_b_d;
            valid_a_q <= valid_a_d;
            valid_b_q <= valid_b_d;
        end
    end

    // A new fill invalidates its bank at once so reads stall until the burst completes.
    always_comb begin
        state_d   = state_q;
        tgt_d     = tgt_q;
        cnt_d     = cnt_q;
        base_a_d  = base_a_q;
        base_b_d  = base_b_q;
        valid_a_d = valid_a_q;
        valid_b_d = valid_b_q;
        case (state_q)
            IDLE: begin
                if (fill_start) begin
                    state_d = FILL;
                    tgt_d   = fill_bank;
                    cnt_d   = '0;
                    if (fill_bank) begin
                        base_b_d  = {fill_base[ADDR_W-1:2], 2'b00};
                        valid_b_d = 1'b0;
                    end else begin
                        base_a_d  = {fill_base[ADDR_W-1:2], 2'b00};
                        valid_a_d = 1'b0;
                    end
                end
            end
            FILL: begin
                if (mem_ack) begin
                    cnt_d = cnt_q + DEPTH_LOG2'(1);
                    if (&cnt_q) begin
                        state_d = IDLE;
                        if (tgt_q) valid_b_d = 1'b1;
                        else       valid_a_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        filling   = (state_q == FILL);
        fill_we_a = filling && mem_ack && !tgt_q;
        fill_we_b = filling && mem_ack && tgt_q;
        mem_addr  = '0;
        if (filling) mem_addr = (tgt_q ? base_b_q : base_a_q) + (ADDR_W'(cnt_q) << 2);

        snoop_word = {snoop_addr[ADDR_W-1:2], 2'b00};
        off_a      = snoop_word - base_a_q;
        off_b      = snoop_word - base_b_q;
        hit_a      = snoop_we && (off_a[ADDR_W-1:DEPTH_LOG2+2] == '0);
        hit_b      = snoop_we && (off_b[ADDR_W-1:DEPTH_LOG2+2] == '0);
        idx_a      = off_a[DEPTH_LOG2+1:2];
        idx_b      = off_b[DEPTH_LOG2+1:2];
        // While filling, only entries already fetched (or being fetched this very cycle) take the store.
        upd_a = hit_a && (valid_a_q || (filling && !tgt_q &&
                ((idx_a < cnt_q) || ((idx_a == cnt_q) && mem_ack))));
        upd_b = hit_b && (valid_b_q || (filling && tgt_q &&
                ((idx_b < cnt_q) || ((idx_b == cnt_q) && mem_ack))));
        unused_low_bits = {fill_base[1:0], snoop_addr[1:0], off_a[1:0] ^ off_b[1:0]};
    end

    // Snoop write is ordered after the fill write so a same-entry collision keeps the store data.
    always_ff @(posedge Clk) begin
        if (Rst_n) begin
            if (fill_we_a) bank_a_q[cnt_q] <= mem_rdata;
            if (upd_a)     bank_a_q[idx_a] <= snoop_data;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst_n) begin
            if (fill_we_b) bank_b_q[cnt_q] <= mem_rdata;
            if (upd_b)     bank_b_q[idx_b] <= snoop_data;
        end
    end

    assign fill_busy        = filling;
    assign mem_req          = filling;
    assign valid_a          = valid_a_q;
    assign valid_b          = valid_b_q;
    assign buf_val_1_select = bank_a_q[buf_val_1_addr];
    assign buf_val_2_select = bank_b_q[buf_val_2_addr];
    assign ld_stall         = (load_buff_a && !valid_a_q) || (load_buff_b && !valid_b_q);

endmodule
